// File: rtl/vc_arb_pkg.sv
// Shared definitions for the VC read arbiter: FSM encoding, default sizes and VC ids.
package vc_arb_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } arb_state_e;

    localparam int unsigned BW_DEFAULT    = 6;
    localparam int unsigned BURST_DEFAULT = 4;

    localparam logic VC0_ID = 1'b0;
    localparam logic VC1_ID = 1'b1;

endpackage

// File: rtl/vc_burst_counter.sv
// Anti-starvation counter: counts VC0 pops while VC1 waits and flags when VC1 must be served.
module vc_burst_counter #(
    parameter int unsigned BURST = 4
) (
    input  logic clk,
    input  logic reset_L,
    input  logic vc0_pop_i,
    input  logic vc1_pop_i,
    input  logic vc1_empty_i,
    output logic force_vc1_o
);

    localparam int unsigned CW = $clog2(BURST + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_burst_q;

    always_comb begin
        cnt_d = cnt_q;
        if (vc1_empty_i || vc1_pop_i) begin
            cnt_d = '0;
        end else if (vc0_pop_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Compare registered alongside the count so the grant flag is a clean flop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q      <= '0;
            at_burst_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_burst_q <= (cnt_d == CW'(BURST));
        end
    end

    assign force_vc1_o = at_burst_q;

endmodule

// File: rtl/vc_read_arbiter.sv
// Drain-side arbiter for VC0/VC1 FIFOs with a two-stage capture pipeline.
// Optional anti-starvation guard enabled by defining VC_STARVE_GUARD_EN.
module vc_read_arbiter
    import vc_arb_pkg::*;
#(
    parameter int unsigned BW    = BW_DEFAULT,
    parameter int unsigned BURST = BURST_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    input  logic          dest_pause,
    output logic          vc0_rd,
    output logic          vc1_rd,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          vc_id_out,
    output logic [1:0]    state
);

    arb_state_e    state_q, state_d;
    logic          iss1_q;
    logic          id1_q;
    logic          valid_q;
    logic          vc_id_q;
    logic [BW-1:0] data_q;

    logic pop_ok, pop_en, take0, take1, force_vc1;

`ifdef VC_STARVE_GUARD_EN
    vc_burst_counter #(
        .BURST(BURST)
    ) u_burst (
        .clk        (clk),
        .reset_L    (reset_L),
        .vc0_pop_i  (vc0_rd),
        .vc1_pop_i  (vc1_rd),
        .vc1_empty_i(vc1_empty),
        .force_vc1_o(force_vc1)
    );
`else
    // BURST has no effect without the guard.
    assign force_vc1 = 1'b0 & (BURST != 0);
`endif

    assign pop_ok = !dest_pause && (!vc0_empty || !vc1_empty);
    assign pop_en = (state_q == ST_ACTIVE) && !dest_pause;

    // VC0 wins unless it is empty or the guard has granted VC1 a turn.
    assign take1  = !vc1_empty && (vc0_empty || force_vc1);
    assign take0  = !vc0_empty && !take1;
    assign vc0_rd = pop_en && take0;
    assign vc1_rd = pop_en && take1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: state_d = pop_ok ? ST_ACTIVE : ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    // Stage 1 tracks the strobe; stage 2 captures the FIFO word returned one cycle later.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            iss1_q  <= 1'b0;
            id1_q   <= VC0_ID;
            valid_q <= 1'b0;
            vc_id_q <= VC0_ID;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            iss1_q  <= vc0_rd || vc1_rd;
            id1_q   <= vc1_rd ? VC1_ID : VC0_ID;
            valid_q <= iss1_q;
            if (iss1_q) begin
                data_q  <= (id1_q == VC1_ID) ? vc1_data : vc0_data;
                vc_id_q <= id1_q;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign vc_id_out = vc_id_q;
    assign state     = 2'(state_q);

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Self-checking bench for vc_read_arbiter: directed steps plus randomized drains
// against a queue-level reference of the pop order.
module tb_vc_read_arbiter;

    localparam int unsigned BW    = 6;
    localparam int unsigned BURST = 4;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          vc0_empty, vc1_empty;
    logic [BW-1:0] vc0_data = '0;
    logic [BW-1:0] vc1_data = '0;
    logic          dest_pause;
    logic          vc0_rd, vc1_rd;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          vc_id_out;
    logic [1:0]    state;

    always #5 clk = ~clk;

    vc_read_arbiter #(.BW(BW), .BURST(BURST)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .vc0_data  (vc0_data),
        .vc1_data  (vc1_data),
        .dest_pause(dest_pause),
        .vc0_rd    (vc0_rd),
        .vc1_rd    (vc1_rd),
        .data_out  (data_out),
        .valid_out (valid_out),
        .vc_id_out (vc_id_out),
        .state     (state)
    );

    // FIFO models: contents only grow from the stimulus side, pops advance a read pointer.
    logic [BW-1:0] mem0 [0:1023];
    logic [BW-1:0] mem1 [0:1023];
    int n0 = 0, n1 = 0;
    int p0 = 0, p1 = 0;

    assign vc0_empty = (p0 >= n0);
    assign vc1_empty = (p1 >= n1);

    always @(posedge clk) begin
        if (vc0_rd) begin
            vc0_data <= mem0[p0];
            p0       <= p0 + 1;
        end
        if (vc1_rd) begin
            vc1_data <= mem1[p1];
            p1       <= p1 + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [1:0] st_last;
    logic [BW-1:0] lq0[$], lq1[$];
    logic [BW:0]   exp_q[$], got[$];
    int pend[$], strb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push0(input logic [BW-1:0] w);
        mem0[n0] = w;
        n0++;
        lq0.push_back(w);
    endtask

    task automatic push1(input logic [BW-1:0] w);
        mem1[n1] = w;
        n1++;
        lq1.push_back(w);
    endtask

    task automatic start();
        got.delete();
        strb.delete();
    endtask

    // One cycle: settle, check invariants, record strobes and delivered words.
    task automatic tick();
        int s;
        #1;
        st_last = state;
        chk("rd_exclusive", 32'(vc0_rd & vc1_rd), 0);
        chk("rd0_on_empty", 32'(vc0_rd & vc0_empty), 0);
        chk("rd1_on_empty", 32'(vc1_rd & vc1_empty), 0);
        if (dest_pause) chk("pause_blocks_rd", 32'(vc0_rd | vc1_rd), 0);
        if (!reset_L) begin
            chk("rst_valid", 32'(valid_out), 0);
            chk("rst_data", 32'(data_out), 0);
            chk("rst_vcid", 32'(vc_id_out), 0);
            chk("rst_state", 32'(state), 0);
            chk("rst_rd", 32'(vc0_rd | vc1_rd), 0);
            pend.delete();
        end
        if (valid_out) begin
            if (pend.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                s = pend.pop_front();
                chk("latency", 32'(cyc - s), 2);
            end
            got.push_back({vc_id_out, data_out});
        end
        if (vc0_rd || vc1_rd) begin
            pend.push_back(cyc);
            strb.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    // Reference pop order from the arbitration rules, applied to whole queues.
    task automatic build_exp();
        int c = 0;
        exp_q.delete();
        while (lq0.size() != 0 || lq1.size() != 0) begin
`ifdef VC_STARVE_GUARD_EN
            if (c == int'(BURST) && lq1.size() != 0) begin
                exp_q.push_back({1'b1, lq1.pop_front()});
                c = 0;
                continue;
            end
`endif
            if (lq0.size() != 0) begin
                exp_q.push_back({1'b0, lq0.pop_front()});
                c = (lq1.size() != 0) ? c + 1 : 0;
            end else begin
                exp_q.push_back({1'b1, lq1.pop_front()});
                c = 0;
            end
        end
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd);
        int k = 0;
        build_exp();
        while (got.size() < exp_q.size() && k < budget) begin
            dest_pause = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
            k++;
        end
        dest_pause = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_word"}, 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int k;
        int g0;
        reset_L    = 1'b0;
        dest_pause = 1'b0;
        @(negedge clk);

        // Reset with both FIFOs holding data, then the RESET/INIT/IDLE/ACTIVE walk.
        start();
        push0(6'h11);
        push1(6'h22);
        for (int i = 0; i < 3; i++) tick();
        reset_L = 1'b1;
        tick();
        chk("init_st_reset", 32'(st_last), 0);
        tick();
        chk("init_st_init", 32'(st_last), 1);
        chk("init_no_rd_init", 32'(strb.size()), 0);
        tick();
        chk("init_st_idle", 32'(st_last), 2);
        chk("init_no_rd_idle", 32'(strb.size()), 0);
        tick();
        chk("init_st_active", 32'(st_last), 3);
        chk("init_first_rd", 32'(strb.size()), 1);
        drain("init", 20, 1'b0);

        // Single-VC drain.
        start();
        push0(6'h05);
        push0(6'h0A);
        push0(6'h3F);
        drain("single", 30, 1'b0);
        chk("single_rd_count", 32'(strb.size()), 3);
        if (strb.size() == 3) chk("single_rd_consec", 32'(strb[2] - strb[0]), 2);

        // Strict priority.
        start();
        push0(6'h01);
        push0(6'h02);
        push1(6'h21);
        push1(6'h22);
        drain("priority", 30, 1'b0);

        // Backpressure mid-drain.
        start();
        for (int i = 0; i < 6; i++) push0(6'(8'h10 + i));
        k = 0;
        while (strb.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        chk("bp_started", 32'(strb.size() >= 2), 1);
        dest_pause = 1'b1;
        g0 = got.size();
        for (int i = 0; i < 6; i++) tick();
        chk("bp_extra_le2", 32'((got.size() - g0) <= 2), 1);
        chk("bp_no_new_rd", 32'(strb.size()), 2);
        drain("backpressure", 40, 1'b0);

        // Starvation scenario: 10 VC0 words against 2 VC1 words.
        start();
        for (int i = 0; i < 10; i++) push0(6'(i + 1));
        push1(6'h30);
        push1(6'h31);
        drain("starve", 60, 1'b0);

        // Reset one cycle after a strobe: the in-flight word is dropped.
        start();
        push0(6'h15);
        k = 0;
        while (strb.size() < 1 && k < 20) begin
            tick();
            k++;
        end
        chk("mrst_strobe_seen", 32'(strb.size()), 1);
        reset_L = 1'b0;
        #1;
        chk("mrst_valid_drop", 32'(valid_out), 0);
        tick();
        tick();
        reset_L = 1'b1;
        lq0.delete();
        push0(6'h2A);
        drain("midreset", 40, 1'b0);

        // Randomized contents and pause pattern.
        for (int it = 0; it < 10; it++) begin
            start();
            dest_pause = 1'b1;
            k = $urandom_range(0, 10);
            for (int i = 0; i < k; i++) push0(6'($urandom));
            k = $urandom_range(0, 5);
            for (int i = 0; i < k; i++) push1(6'($urandom));
            drain("random", 300, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
